// File: rtl/spi_rxblock_pkg.sv
// Shared constants and state encoding for the SPI block-read engine.
package spi_rxblock_pkg;

  localparam logic [15:0] CrcPoly    = 16'h1021;
  localparam logic [7:0]  StartToken = 8'hFE;
  localparam logic [7:0]  IdleByte   = 8'hFF;
  localparam logic [7:0]  RspOk      = 8'h00;
  localparam logic [7:0]  RspCrcErr  = 8'h40;
  localparam logic [7:0]  RspTimeout = 8'h80;

  typedef enum logic [2:0] {
    StIdle,
    StToken,
    StData,
    StCrcHi,
    StCrcLo,
    StDone
  } rx_state_e;

endpackage

// File: rtl/spi_crc16.sv
// Byte-wide CRC16-CCITT update, MSB first; purely combinational.
module spi_crc16
  import spi_rxblock_pkg::*;
(
  input  logic [15:0] i_crc,
  input  logic [7:0]  i_byte,
  output logic [15:0] o_crc
);

  logic [15:0] c;

  always_comb begin
    c = i_crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ i_byte[i]) c = {c[14:0], 1'b0} ^ CrcPoly;
      else                   c = {c[14:0], 1'b0};
    end
    o_crc = c;
  end

endmodule

// File: rtl/spi_rxblock.sv
// Reads one data block from an SD card over a byte-level SPI link: waits for the start
// token, writes the payload into one half of a word memory and checks the trailing CRC.
module spi_rxblock
  import spi_rxblock_pkg::*;
#(
  parameter int unsigned DW        = 32,
  parameter int unsigned AW        = 8,
  parameter int unsigned LGTIMEOUT = 16
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic [3:0]    i_lgblksz,
  input  logic          i_fifo,
  output logic          o_busy,
  input  logic          i_ll_busy,
  output logic          o_ll_stb,
  output logic [7:0]    o_ll_byte,
  input  logic          i_ll_stb,
  input  logic [7:0]    i_ll_byte,
  output logic          o_write,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data,
  output logic          o_rxvalid,
  output logic [7:0]    o_response
);

  localparam int unsigned BytesPerWord = DW / 8;

  rx_state_e          state_q, state_d;
  logic               pend_q, pend_d;
  logic [3:0]         lg_q, lg_d;
  logic [9:0]         bcnt_q, bcnt_d;
  logic [7:0]         wcnt_q, wcnt_d;
  logic [LGTIMEOUT:0] tcnt_q, tcnt_d;
  logic [15:0]        crc_q, crc_d, crc_next;
  logic [7:0]         crc_hi_q, crc_hi_d;
  logic [DW-1:0]      data_q, data_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic               write_q, write_d;
  logic               rxvalid_q, rxvalid_d;
  logic [7:0]         resp_q, resp_d;
  logic               active, rx_byte;
  logic [9:0]         last_byte;

  spi_crc16 u_crc (
    .i_crc  (crc_q),
    .i_byte (i_ll_byte),
    .o_crc  (crc_next)
  );

  assign active     = (state_q == StToken) || (state_q == StData) ||
                      (state_q == StCrcHi) || (state_q == StCrcLo);
  assign o_ll_stb   = active && !pend_q;
  assign o_ll_byte  = IdleByte;
  assign rx_byte    = pend_q && i_ll_stb;
  assign last_byte  = (10'd1 << lg_q) - 10'd1;
  assign o_busy     = (state_q != StIdle);
  assign o_write    = write_q;
  assign o_addr     = addr_q;
  assign o_data     = data_q;
  assign o_rxvalid  = rxvalid_q;
  assign o_response = resp_q;

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    lg_d      = lg_q;
    bcnt_d    = bcnt_q;
    wcnt_d    = wcnt_q;
    tcnt_d    = tcnt_q;
    crc_d     = crc_q;
    crc_hi_d  = crc_hi_q;
    data_d    = data_q;
    addr_d    = addr_q;
    write_d   = 1'b0;
    rxvalid_d = 1'b0;
    resp_d    = resp_q;

    // Exactly one byte in flight: request, then wait for its reply.
    if (o_ll_stb && !i_ll_busy) pend_d = 1'b1;
    if (rx_byte)                pend_d = 1'b0;
    // The FIFO-half select bit is never carried into.
    if (write_q) addr_d = {addr_q[AW-1], addr_q[AW-2:0] + 1'b1};

    case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = StToken;
          if (i_lgblksz < 4'd4)      lg_d = 4'd4;
          else if (i_lgblksz > 4'd9) lg_d = 4'd9;
          else                       lg_d = i_lgblksz;
          addr_d = {i_fifo, {(AW-1){1'b0}}};
          tcnt_d = '0;
          bcnt_d = '0;
          wcnt_d = '0;
          crc_d  = '0;
        end
      end
      StToken: begin
        if (rx_byte) begin
          if (i_ll_byte == StartToken) begin
            state_d = StData;
          end else if (i_ll_byte[7:4] == 4'h0) begin
            state_d   = StDone;
            rxvalid_d = 1'b1;
            resp_d    = {4'h0, i_ll_byte[3:0]};
          end else begin
            tcnt_d = tcnt_q + 1'b1;
            if (tcnt_d[LGTIMEOUT]) begin
              state_d   = StDone;
              rxvalid_d = 1'b1;
              resp_d    = RspTimeout;
            end
          end
        end
      end
      StData: begin
        if (rx_byte) begin
          data_d = DW'({data_q, i_ll_byte});
          crc_d  = crc_next;
          bcnt_d = bcnt_q + 10'd1;
          if (wcnt_q == 8'(BytesPerWord - 1)) begin
            write_d = 1'b1;
            wcnt_d  = '0;
          end else begin
            wcnt_d = wcnt_q + 8'd1;
          end
          if (bcnt_q == last_byte) state_d = StCrcHi;
        end
      end
      StCrcHi: begin
        if (rx_byte) begin
          crc_hi_d = i_ll_byte;
          state_d  = StCrcLo;
        end
      end
      StCrcLo: begin
        if (rx_byte) begin
          state_d   = StDone;
          rxvalid_d = 1'b1;
          resp_d    = ({crc_hi_q, i_ll_byte} == crc_q) ? RspOk : RspCrcErr;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= StIdle;
      pend_q    <= 1'b0;
      lg_q      <= 4'd4;
      bcnt_q    <= '0;
      wcnt_q    <= '0;
      tcnt_q    <= '0;
      crc_q     <= '0;
      crc_hi_q  <= '0;
      data_q    <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      rxvalid_q <= 1'b0;
      resp_q    <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      lg_q      <= lg_d;
      bcnt_q    <= bcnt_d;
      wcnt_q    <= wcnt_d;
      tcnt_q    <= tcnt_d;
      crc_q     <= crc_d;
      crc_hi_q  <= crc_hi_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      rxvalid_q <= rxvalid_d;
      resp_q    <= resp_d;
    end
  end

endmodule
